setpoint_capture: RTL and testbench
===================================

SETPOINT_CAPTURE -- requirements
Module: setpoint_capture

Interface
REQ-001 The block SHALL have parameter RESULT_COUNT, default 32: setpoints per frame, minimum 2.
REQ-002 The block SHALL have parameter GAP_TIMEOUT, default 255: maximum idle cycles allowed between beats inside a frame.
REQ-003 The block SHALL use ADDR_WIDTH = clog2(RESULT_COUNT) as a derived width.
REQ-004 The block SHALL have the port list below; there is one clock, and reset is asynchronous and active-high.
- clk  input  1  sole clock
- reset  input  1  asynchronous, active-high
- SETPOINT_TVALID  input  1  stream beat valid; there is no TREADY, so every beat is accepted
- SETPOINT_TLAST  input  1  last beat of frame
- SETPOINT_TDATA  input  32  floating-point setpoint
- clearStrobe  input  1  clears sticky error bits
- readAddress  input  ADDR_WIDTH  setpoint index to read back
- readData  output  32  setpoint at readAddress, taken from the published bank
- frameToggle  output  1  inverts on each published frame
- status  output  32  see REQ-015

Function
REQ-005 Storage SHALL be two banks of RESULT_COUNT x 32; the capture bank is the complement of the published bank pubSel.
REQ-006 The state machine SHALL have the states IDLE, RECV and DISCARD.
REQ-007 In IDLE, a beat SHALL be written to the capture bank at index 0 and set index to 1.
- If the IDLE beat also has TLAST, it is an unexpected TLAST: the state stays IDLE.
- Otherwise the state goes to RECV.
REQ-008 In RECV, each beat SHALL be written at the current index, and index increments.
REQ-009 In RECV, TLAST at index == RESULT_COUNT-1 SHALL publish the frame, then return to IDLE.
- Publishing means: pubSel inverts, frameToggle inverts, frameCount increments.
- All three change in the cycle after the TLAST beat.
REQ-010 In RECV, TLAST at index < RESULT_COUNT-1 SHALL set tlastUnexpected, discard the frame (no publish) and return to IDLE.
REQ-011 In RECV, a beat without TLAST at index == RESULT_COUNT-1 SHALL be written, then the state goes to DISCARD.
- The next beat in DISCARD is the overflow: it sets tlastMissing.
REQ-012 In DISCARD, beats SHALL be dropped until a TLAST beat, then the state returns to IDLE with no publish.
- A TLAST on the overflow beat itself still sets tlastMissing.
REQ-013 In RECV or DISCARD, GAP_TIMEOUT consecutive cycles without TVALID SHALL set gapTimeout and abort to IDLE with no publish.
- The gap counter clears on each beat.
REQ-014 readData SHALL be registered, valid 1 cycle after readAddress.
- Addresses >= RESULT_COUNT return 0.
- A publish coincident with a read switches the source bank from the next cycle onward.
REQ-015 status SHALL be laid out as follows.
- [31:16] frameCount, 16 bits, wraps 0xFFFF->0.
- [3] busy (state != IDLE).
- [2] gapTimeout, sticky.
- [1] tlastUnexpected, sticky.
- [0] tlastMissing, sticky.
- [15:4] are 0.
REQ-016 clearStrobe SHALL clear bits [2:0]; a set event in the same cycle as clearStrobe SHALL win (bit reads 1).
REQ-017 The published bank SHALL never be written; a partial or errored frame SHALL never become visible on readData.

Reset
REQ-018 On reset assertion, the block SHALL go immediately to the following state regardless of clk.
- state=IDLE, index=0, gap counter=0.
- pubSel=0, frameToggle=0, frameCount=0.
- Sticky bits=0, readData=0.
REQ-019 A frame in progress at reset SHALL be discarded; bank RAM contents are not initialised.
REQ-020 After reset deassertion, the first beat SHALL be treated as the start of a frame.

Verification
REQ-021 Good frame: RESULT_COUNT=4, beats 0x3F800000, 0x40000000, 0x40400000, 0x40800000 with TLAST on the 4th -> next cycle frameToggle=1, status=0x00010000; readAddress=2 returns 0x40400000 one cycle later.
REQ-022 Short frame: 2 beats with TLAST on the 2nd after a good frame -> status[1]=1, frameToggle and frameCount unchanged, readback still returns the prior frame's data.
REQ-023 Long frame: 6 beats with TLAST on the 6th -> status[0]=1, no publish; the following good 4-beat frame publishes normally, frameCount=1.
REQ-024 Gap: GAP_TIMEOUT=8, 2 beats then TVALID low for 8 cycles -> status[2]=1, busy=0; the next 4-beat frame publishes.
REQ-025 Clear race: clearStrobe asserted in the same cycle as an unexpected-TLAST beat -> status[1]=1; clearStrobe alone on the next cycle -> status[1]=0.
REQ-026 Reset mid-frame: reset asserted after 2 of 4 beats -> all outputs 0 immediately; a subsequent full frame publishes, frameCount=1.

Source files
------------

// File: rtl/setpoint_capture.sv
// Double-buffered setpoint frame capture from a TREADY-less stream.
// A full frame lands in the hidden bank and is published atomically with a bank swap.
module setpoint_capture #(
    parameter int RESULT_COUNT = 32,
    parameter int GAP_TIMEOUT  = 255,
    localparam int ADDR_WIDTH  = $clog2(RESULT_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SETPOINT_TVALID,
    input  logic                  SETPOINT_TLAST,
    input  logic [31:0]           SETPOINT_TDATA,
    input  logic                  clearStrobe,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [31:0]           readData,
    output logic                  frameToggle,
    output logic [31:0]           status
);

    localparam int GAP_WIDTH = $clog2(GAP_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(RESULT_COUNT - 1);
    localparam logic [GAP_WIDTH-1:0]  GAP_LAST   = GAP_WIDTH'(GAP_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH + 1)'(RESULT_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] index, index_next;
    logic [GAP_WIDTH-1:0]  gap_count, gap_next;
    logic                  overflow_pending, overflow_next;
    logic                  pub_sel;
    logic [15:0]           frame_count;
    logic [2:0]            sticky;
    logic                  write_en;
    logic                  publish;
    logic                  set_gap, set_unexpected, set_missing;

    logic [31:0] bank [0:1][0:RESULT_COUNT-1];

    always_comb begin
        state_next     = state;
        index_next     = index;
        gap_next       = gap_count;
        overflow_next  = overflow_pending;
        write_en       = 1'b0;
        publish        = 1'b0;
        set_gap        = 1'b0;
        set_unexpected = 1'b0;
        set_missing    = 1'b0;

        case (state)
            IDLE: begin
                gap_next = '0;
                if (SETPOINT_TVALID) begin
                    write_en = 1'b1;
                    if (SETPOINT_TLAST) begin
                        // A one-beat frame can never be complete.
                        set_unexpected = 1'b1;
                        index_next     = '0;
                    end else begin
                        index_next = ADDR_WIDTH'(1);
                        state_next = RECV;
                    end
                end
            end

            RECV: begin
                if (SETPOINT_TVALID) begin
                    gap_next = '0;
                    write_en = 1'b1;
                    if (SETPOINT_TLAST) begin
                        index_next = '0;
                        state_next = IDLE;
                        if (index == LAST_INDEX) begin
                            publish = 1'b1;
                        end else begin
                            set_unexpected = 1'b1;
                        end
                    end else if (index == LAST_INDEX) begin
                        index_next    = '0;
                        overflow_next = 1'b1;
                        state_next    = DISCARD;
                    end else begin
                        index_next = index + 1'b1;
                    end
                end else if (gap_count == GAP_LAST) begin
                    set_gap    = 1'b1;
                    gap_next   = '0;
                    index_next = '0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_count + 1'b1;
                end
            end

            DISCARD: begin
                if (SETPOINT_TVALID) begin
                    gap_next = '0;
                    // Only the first beat past a full frame counts as the overflow.
                    if (overflow_pending) begin
                        set_missing   = 1'b1;
                        overflow_next = 1'b0;
                    end
                    if (SETPOINT_TLAST) begin
                        overflow_next = 1'b0;
                        state_next    = IDLE;
                    end
                end else if (gap_count == GAP_LAST) begin
                    set_gap       = 1'b1;
                    gap_next      = '0;
                    overflow_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    gap_next = gap_count + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                index_next = '0;
                gap_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            index            <= '0;
            gap_count        <= '0;
            overflow_pending <= 1'b0;
            pub_sel          <= 1'b0;
            frameToggle      <= 1'b0;
            frame_count      <= '0;
            sticky           <= '0;
            readData         <= '0;
        end else begin
            state            <= state_next;
            index            <= index_next;
            gap_count        <= gap_next;
            overflow_pending <= overflow_next;
            if (publish) begin
                pub_sel     <= ~pub_sel;
                frameToggle <= ~frameToggle;
                frame_count <= frame_count + 16'd1;
            end
            // Set events override a simultaneous clear.
            sticky <= (sticky & ~{3{clearStrobe}}) | {set_gap, set_unexpected, set_missing};
            if ({1'b0, readAddress} < ADDR_LIMIT) begin
                readData <= bank[pub_sel][readAddress];
            end else begin
                readData <= '0;
            end
        end
    end

    // Writes only ever target the hidden bank, so the published frame stays intact.
    always_ff @(posedge clk) begin
        if (write_en) begin
            bank[~pub_sel][index] <= SETPOINT_TDATA;
        end
    end

    assign status = {frame_count, 12'd0, (state != IDLE), sticky};

endmodule

// File: tb/tb_setpoint_capture.sv
// Directed bench for setpoint_capture with RESULT_COUNT=4, GAP_TIMEOUT=8.
// A vector table walks good, short, long, gap and clear cases; reset mid-frame is hand-written.
module tb_setpoint_capture;

    localparam int RC  = 4;
    localparam int GAP = 8;

    logic        clk;
    logic        reset;
    logic        tvalid;
    logic        tlast;
    logic [31:0] tdata;
    logic        clear_strobe;
    logic [1:0]  read_address;
    logic [31:0] read_data;
    logic        frame_toggle;
    logic [31:0] status;

    setpoint_capture #(
        .RESULT_COUNT(RC),
        .GAP_TIMEOUT (GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .SETPOINT_TVALID(tvalid),
        .SETPOINT_TLAST (tlast),
        .SETPOINT_TDATA (tdata),
        .clearStrobe    (clear_strobe),
        .readAddress    (read_address),
        .readData       (read_data),
        .frameToggle    (frame_toggle),
        .status         (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic        clr;
        logic [1:0]  raddr;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_tog;
        logic [31:0] exp_st;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic v(input logic valid, input logic last, input logic [31:0] data,
                     input logic clr, input logic [1:0] raddr, input logic chk_rd,
                     input logic [31:0] exp_rd, input logic exp_tog, input logic [31:0] exp_st);
        vec_t e;
        e.valid = valid; e.last = last; e.data = data; e.clr = clr; e.raddr = raddr;
        e.chk_rd = chk_rd; e.exp_rd = exp_rd; e.exp_tog = exp_tog; e.exp_st = exp_st;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic drive(input logic valid, input logic last, input logic [31:0] data,
                         input logic clr, input logic [1:0] raddr);
        tvalid       = valid;
        tlast        = last;
        tdata        = data;
        clear_strobe = clr;
        read_address = raddr;
    endtask

    task automatic beat(input logic last, input logic [31:0] data);
        drive(1'b1, last, data, 1'b0, 2'd0);
        @(negedge clk);
    endtask

    initial begin
        // good frame
        v(1,0,32'h3F800000,0,0,0,0,0,32'h00000008);
        v(1,0,32'h40000000,0,0,0,0,0,32'h00000008);
        v(1,0,32'h40400000,0,0,0,0,0,32'h00000008);
        v(1,1,32'h40800000,0,2,0,0,1,32'h00010000);
        v(0,0,0,0,2,1,32'h40400000,1,32'h00010000);
        v(0,0,0,0,0,1,32'h3F800000,1,32'h00010000);
        v(0,0,0,0,3,1,32'h40800000,1,32'h00010000);
        // short frame: prior data stays visible
        v(1,0,32'h11111111,0,0,1,32'h3F800000,1,32'h00010008);
        v(1,1,32'h22222222,0,1,1,32'h40000000,1,32'h00010002);
        v(0,0,0,0,1,1,32'h40000000,1,32'h00010002);
        v(0,0,0,1,2,1,32'h40400000,1,32'h00010000);
        // long frame, then a good one; publish coincides with a read of the old bank
        for (int i = 0; i < 4; i++) v(1,0,32'hA0000000 + i,0,0,0,0,1,32'h00010008);
        v(1,0,32'hA0000004,0,0,0,0,1,32'h00010009);
        v(1,1,32'hA0000005,0,0,0,0,1,32'h00010001);
        v(1,0,32'h41000000,0,0,0,0,1,32'h00010009);
        v(1,0,32'h41100000,0,0,0,0,1,32'h00010009);
        v(1,0,32'h41200000,0,0,0,0,1,32'h00010009);
        v(1,1,32'h41300000,0,0,1,32'h3F800000,0,32'h00020001);
        v(0,0,0,0,1,1,32'h41100000,0,32'h00020001);
        v(0,0,0,1,3,1,32'h41300000,0,32'h00020000);
        // gap timeout: 2 beats then 8 idle cycles
        v(1,0,32'h51,0,0,0,0,0,32'h00020008);
        v(1,0,32'h52,0,0,0,0,0,32'h00020008);
        for (int i = 0; i < GAP - 1; i++) v(0,0,0,0,0,0,0,0,32'h00020008);
        v(0,0,0,0,0,0,0,0,32'h00020004);
        // 7 idle cycles inside a frame is tolerated
        v(1,0,32'h42000000,0,0,0,0,0,32'h0002000C);
        v(1,0,32'h42100000,0,0,0,0,0,32'h0002000C);
        for (int i = 0; i < GAP - 1; i++) v(0,0,0,0,0,0,0,0,32'h0002000C);
        v(1,0,32'h42200000,0,0,0,0,0,32'h0002000C);
        v(1,1,32'h42300000,0,0,0,0,1,32'h00030004);
        v(0,0,0,0,2,1,32'h42200000,1,32'h00030004);
        v(0,0,0,1,0,1,32'h42000000,1,32'h00030000);
        // TLAST on the first beat of a frame
        v(1,1,32'hDEAD0001,0,0,1,32'h42000000,1,32'h00030002);
        v(0,0,0,1,0,1,32'h42000000,1,32'h00030000);
        // clear coincident with an unexpected TLAST: set wins
        v(1,0,32'h61,0,0,1,32'h42000000,1,32'h00030008);
        v(1,1,32'h62,1,0,1,32'h42000000,1,32'h00030002);
        v(0,0,0,1,0,1,32'h42000000,1,32'h00030000);
        // TLAST on the overflow beat itself
        for (int i = 0; i < 4; i++) v(1,0,32'h71 + i,0,0,0,0,1,32'h00030008);
        v(1,1,32'h75,0,0,0,0,1,32'h00030001);
        v(0,0,0,0,1,1,32'h42100000,1,32'h00030001);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_read_data", read_data, 32'h0);
        check("reset_toggle", {31'd0, frame_toggle}, 32'h0);
        check("reset_status", status, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].clr, vecs[i].raddr);
            @(negedge clk);
            check($sformatf("vec%0d_status", i), status, vecs[i].exp_st);
            check($sformatf("vec%0d_toggle", i), {31'd0, frame_toggle}, {31'd0, vecs[i].exp_tog});
            if (vecs[i].chk_rd) check($sformatf("vec%0d_read", i), read_data, vecs[i].exp_rd);
        end

        // reset mid-frame acts immediately, without a clock edge
        beat(1'b0, 32'h81);
        beat(1'b0, 32'h82);
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_read_data", read_data, 32'h0);
        check("async_reset_toggle", {31'd0, frame_toggle}, 32'h0);
        check("async_reset_status", status, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        beat(1'b0, 32'h43000000);
        beat(1'b0, 32'h43100000);
        beat(1'b0, 32'h43200000);
        beat(1'b1, 32'h43300000);
        check("post_reset_status", status, 32'h00010000);
        check("post_reset_toggle", {31'd0, frame_toggle}, 32'h1);
        drive(0, 0, 0, 0, 2'd3);
        @(negedge clk);
        check("post_reset_read3", read_data, 32'h43300000);
        drive(0, 0, 0, 0, 2'd0);
        @(negedge clk);
        check("post_reset_read0", read_data, 32'h43000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
